// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared opcode and read-select codes for the multiply/divide unit
// Purpose: MD_* operation codes driven on mdOp and MD_RD_* codes driven on rdSel,
//          shared by the controller, the unit and its arithmetic core.
// Ports: none (package).
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } mdOp_e;

    localparam logic MD_RD_LO = 1'b0;
    localparam logic MD_RD_HI = 1'b1;

    // True for the four opcodes that start a multi-cycle operation.
    function automatic logic isArithOp(input logic [2:0] op);
        return (op >= 3'(MD_MULT)) && (op <= 3'(MD_DIVU));
    endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// rtl/mult_div_unit_md_arith.sv - combinational 32x32 multiply/divide core
// Purpose: produces the 64-bit {resHi,resLo} result for MULT/MULTU/DIV/DIVU,
//          including the divide-by-zero and signed-overflow results.
// Ports:
//   mdOp  in  3   operation code (non-arithmetic codes give a zero result)
//   opA   in  32  multiplicand / dividend
//   opB   in  32  multiplier / divisor
//   resHi out 32  product high word / remainder
//   resLo out 32  product low word / quotient
module md_arith
    import mult_div_unit_pkg::*;
(
    input  logic [2:0]  mdOp,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [31:0] resHi,
    output logic [31:0] resLo
);

    logic signed [63:0] sProd;
    logic [63:0]        uProd;
    logic               divByZero;
    logic [31:0]        safeB;
    logic [31:0]        absA;
    logic [31:0]        absB;
    logic [31:0]        uQuot;
    logic [31:0]        uRem;
    logic [31:0]        mQuot;
    logic [31:0]        mRem;
    logic [31:0]        sQuot;
    logic [31:0]        sRem;
    logic               sOverflow;

    assign sProd = $signed({{32{opA[31]}}, opA}) * $signed({{32{opB[31]}}, opB});
    assign uProd = {32'd0, opA} * {32'd0, opB};

    // The divisor is forced non-zero so the dividers never see zero; the
    // zero case is replaced by the architectural result below.
    assign divByZero = (opB == 32'd0);
    assign safeB     = divByZero ? 32'd1 : opB;

    assign uQuot = opA / safeB;
    assign uRem  = opA % safeB;

    // Signed divide on magnitudes: 0x80000000 negates to itself, which is
    // exactly 2^31 when read as unsigned.
    assign absA  = opA[31] ? (32'd0 - opA) : opA;
    assign absB  = safeB[31] ? (32'd0 - safeB) : safeB;
    assign mQuot = absA / absB;
    assign mRem  = absA % absB;
    assign sQuot = (opA[31] ^ safeB[31]) ? (32'd0 - mQuot) : mQuot;
    assign sRem  = opA[31] ? (32'd0 - mRem) : mRem;

    assign sOverflow = (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);

    always_comb begin
        resHi = 32'd0;
        resLo = 32'd0;
        case (mdOp)
            3'(MD_MULT): begin
                resHi = sProd[63:32];
                resLo = sProd[31:0];
            end
            3'(MD_MULTU): begin
                resHi = uProd[63:32];
                resLo = uProd[31:0];
            end
            3'(MD_DIV): begin
                if (divByZero) begin
                    resHi = opA;
                    resLo = 32'hFFFF_FFFF;
                end else if (sOverflow) begin
                    resHi = 32'd0;
                    resLo = 32'h8000_0000;
                end else begin
                    resHi = sRem;
                    resLo = sQuot;
                end
            end
            3'(MD_DIVU): begin
                if (divByZero) begin
                    resHi = opA;
                    resLo = 32'hFFFF_FFFF;
                end else begin
                    resHi = uRem;
                    resLo = uQuot;
                end
            end
            default: begin
                resHi = 32'd0;
                resLo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - EX-stage multiply/divide unit owning the HI/LO registers
// Purpose: starts multi-cycle MULT/MULTU/DIV/DIVU operations, holds busy for a
//          fixed latency, then commits the pending result to HI/LO. MTHI/MTLO
//          write HI/LO directly; rdData returns HI or LO for MFHI/MFLO.
// Ports:
//   clk    in  1   clock, rising edge
//   rst_n  in  1   asynchronous active-low reset
//   mdOp   in  3   operation code (mult_div_unit_pkg::mdOp_e)
//   opA    in  32  rs operand / MTHI-MTLO data
//   opB    in  32  rt operand
//   rdSel  in  1   0 reads LO, 1 reads HI
//   busy   out 1   operation in flight
//   rdData out 32  committed HI or LO
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  mdOp,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        rdSel,
    output logic        busy,
    output logic [31:0] rdData
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] counter;
    logic [31:0]      hiReg;
    logic [31:0]      loReg;
    logic [31:0]      pendHi;
    logic [31:0]      pendLo;
    logic [31:0]      resHi;
    logic [31:0]      resLo;

    md_arith uArith (
        .mdOp  (mdOp),
        .opA   (opA),
        .opB   (opB),
        .resHi (resHi),
        .resLo (resLo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            pendHi  <= 32'd0;
            pendLo  <= 32'd0;
        end else if (counter != '0) begin
            // In flight: every new request is dropped; commit on the last count.
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) begin
                hiReg <= pendHi;
                loReg <= pendLo;
            end
        end else begin
            if (isArithOp(mdOp)) begin
                pendHi  <= resHi;
                pendLo  <= resLo;
                counter <= (mdOp == 3'(MD_DIV) || mdOp == 3'(MD_DIVU))
                           ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (mdOp == 3'(MD_MTHI)) begin
                hiReg <= opA;
            end else if (mdOp == 3'(MD_MTLO)) begin
                loReg <= opA;
            end
        end
    end

    // Derived directly from the counter register, so it drops with reset.
    assign busy   = (counter != '0);
    assign rdData = (rdSel == MD_RD_HI) ? hiReg : loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mdOp;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        rdSel;
    logic        busy;
    logic [31:0] rdData;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mdOp   (mdOp),
        .opA    (opA),
        .opB    (opB),
        .rdSel  (rdSel),
        .busy   (busy),
        .rdData (rdData)
    );

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] rdQ[$];
    string       rdNameQ[$];
    int          latQ[$];
    logic        rdStrobe = 1'b0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    int          runLen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        nChecks++;
        nFails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference results straight from the architectural rules.
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        logic [31:0]     q, r;
        case (op)
            3'(MD_MULT): begin
                sa = a; sb = b;
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            3'(MD_MULTU): begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                return up;
            end
            3'(MD_DIV): begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a; sb = b;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            3'(MD_DIVU): begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Monitor: compares reads and busy-run lengths against queued expectations.
    always @(negedge clk) begin
        if (!rst_n) begin
            runLen = 0;
        end else begin
            if (rdStrobe) begin
                if (rdQ.size() == 0) failNow("rdData unexpected read");
                else check(rdNameQ.pop_front(), rdData, rdQ.pop_front());
            end
            if (busy) begin
                runLen++;
            end else if (runLen > 0) begin
                if (latQ.size() == 0) failNow("busy unexpected run");
                else check("busy length", 32'(runLen), 32'(latQ.pop_front()));
                runLen = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mdOp = op;
        opA  = a;
        opB  = b;
        tick();
        mdOp = 3'(MD_NONE);
        opA  = $urandom;
        opB  = $urandom;
    endtask

    task automatic readBack(input string tag);
        rdQ.push_back(mLo);
        rdNameQ.push_back({tag, " LO"});
        rdSel    = MD_RD_LO;
        rdStrobe = 1'b1;
        tick();
        rdQ.push_back(mHi);
        rdNameQ.push_back({tag, " HI"});
        rdSel = MD_RD_HI;
        tick();
        rdStrobe = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) failNow("waitIdle timeout");
    endtask

    task automatic doOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        logic [63:0] r;
        if (isArithOp(op)) begin
            r = refResult(op, a, b);
            latQ.push_back((op == 3'(MD_DIV) || op == 3'(MD_DIVU)) ? DIV_N : MULT_N);
            issue(op, a, b);
            readBack({tag, " old"});
            waitIdle();
            mHi = r[63:32];
            mLo = r[31:0];
            readBack(tag);
        end else begin
            issue(op, a, b);
            if (op == 3'(MD_MTHI)) mHi = a;
            if (op == 3'(MD_MTLO)) mLo = a;
            check({tag, " busy"}, {31'd0, busy}, 32'd0);
            readBack(tag);
        end
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] edges[6];
        edges = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd2};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        rst_n = 1'b0;
        mdOp  = 3'(MD_NONE);
        opA   = 32'd0;
        opB   = 32'd0;
        rdSel = MD_RD_HI;
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rdData HI", rdData, 32'd0);
        rdSel = MD_RD_LO;
        #1;
        check("reset rdData LO", rdData, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        doOp("mult", 3'(MD_MULT), 32'hFFFF_FFFF, 32'd2);
        check("mult HI", mHi, 32'hFFFF_FFFF);
        check("mult LO", mLo, 32'hFFFF_FFFE);
        doOp("multu", 3'(MD_MULTU), 32'hFFFF_FFFF, 32'd2);
        doOp("div", 3'(MD_DIV), 32'hFFFF_FFF9, 32'd2);
        doOp("divu0", 3'(MD_DIVU), 32'd7, 32'd0);
        doOp("div0", 3'(MD_DIV), 32'h8765_4321, 32'd0);
        doOp("divovf", 3'(MD_DIV), 32'h8000_0000, 32'hFFFF_FFFF);
        doOp("mthi", 3'(MD_MTHI), 32'h0000_1234, 32'd0);
        doOp("mtlo", 3'(MD_MTLO), 32'h0000_5678, 32'd0);
        doOp("rsvd", 3'(MD_RSVD), 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // DIV presented on busy cycle 2 of a MULT must be dropped.
        latQ.push_back(MULT_N);
        issue(3'(MD_MULT), 32'h0001_0000, 32'h0003_0000);
        tick();
        issue(3'(MD_DIV), 32'd100, 32'd3);
        waitIdle();
        {mHi, mLo} = refResult(3'(MD_MULT), 32'h0001_0000, 32'h0003_0000);
        readBack("ignored div");

        // Reset during busy cycle 3 of a DIV.
        latQ.push_back(DIV_N);
        issue(3'(MD_DIV), 32'd1000, 32'd7);
        tick();
        tick();
        rst_n = 1'b0;
        latQ.delete();
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        rdSel = MD_RD_HI;
        #1;
        check("midreset HI", rdData, 32'd0);
        rdSel = MD_RD_LO;
        #1;
        check("midreset LO", rdData, 32'd0);
        mHi = 32'd0;
        mLo = 32'd0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post-reset busy", {31'd0, busy}, 32'd0);
        end
        readBack("post-reset");

        for (int i = 0; i < 40; i++) begin
            doOp("random", 3'($urandom_range(0, 7)), pickOperand(), pickOperand());
        end

        tick();
        tick();
        check("rdQ drained", 32'(rdQ.size()), 32'd0);
        check("latQ drained", 32'(latQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
